// File: rtl/accumulator_ctrl.sv
// rtl/accumulator_ctrl.sv - per-tile sequencer for the column accumulator and output buffer
//
// Walks each output tile through four phases: clear the accumulator, gate
// accumulation for k_len partial-sum beats, drain ARR_SIZE lanes to the output
// buffer at consecutive (wrapping) addresses, and then pulse done.
//
// Optional feature macro: ACC_CTRL_PERF_EN adds a saturating stall counter
// (stall_cnt) and its clear input (stall_clr).
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous reset, active-low
//   start             one-cycle tile launch request
//   k_len             partial-sum beats to accumulate, sampled on accepted start
//   base_addr         first output buffer address, sampled on accepted start
//   psum_valid        array presents a valid partial-sum beat
//   ob_ready          output buffer accepts a word this cycle
//   stall_clr         (ACC_CTRL_PERF_EN) clears stall_cnt
//   stall_cnt         (ACC_CTRL_PERF_EN) ACCUM/STORE stall cycles, saturating
//   acc_reset         clears accumulator state
//   acc_en            accumulator adds the current beat
//   store_output      accumulator writes one lane to the output buffer
//   op_buffer_address write address for the current lane
//   busy              tile in progress
//   done              one-cycle tile-complete pulse
//   err               one-cycle pulse: start rejected because k_len == 0

module accumulator_ctrl #(
  parameter int ARR_SIZE = 4,
  parameter int K_W      = 8,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              psum_valid,
  input  logic              ob_ready,
`ifdef ACC_CTRL_PERF_EN
  input  logic              stall_clr,
  output logic [15:0]       stall_cnt,
`endif
  output logic              acc_reset,
  output logic              acc_en,
  output logic              store_output,
  output logic [ADDR_W-1:0] op_buffer_address,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LANE_W = (ARR_SIZE > 1) ? $clog2(ARR_SIZE) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(ARR_SIZE - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state;
  logic [K_W-1:0]    k_len_q;
  logic [K_W-1:0]    beat_cnt;
  logic [ADDR_W-1:0] base_q;
  logic [LANE_W-1:0] lane;

  // Registered phase flags: acc_en/store_output are these ANDed with the
  // handshake inputs, so they never glitch on a state decode.
  logic accum_q;
  logic store_q;

  assign acc_en       = accum_q & psum_valid;
  assign store_output = store_q & ob_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= S_IDLE;
      k_len_q           <= '0;
      beat_cnt          <= '0;
      base_q            <= '0;
      lane              <= '0;
      accum_q           <= 1'b0;
      store_q           <= 1'b0;
      acc_reset         <= 1'b0;
      op_buffer_address <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      acc_reset <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              k_len_q   <= k_len;
              base_q    <= base_addr;
              acc_reset <= 1'b1;
              busy      <= 1'b1;
              state     <= S_CLEAR;
            end else begin
              err <= 1'b1;
            end
          end
        end

        S_CLEAR: begin
          beat_cnt <= '0;
          accum_q  <= 1'b1;
          state    <= S_ACCUM;
        end

        S_ACCUM: begin
          if (psum_valid) begin
            beat_cnt <= beat_cnt + K_W'(1);
            if (beat_cnt == k_len_q - K_W'(1)) begin
              accum_q           <= 1'b0;
              store_q           <= 1'b1;
              lane              <= '0;
              op_buffer_address <= base_q;
              state             <= S_STORE;
            end
          end
        end

        S_STORE: begin
          // The address register tracks base + lane incrementally; ADDR_W
          // arithmetic gives the wrap for free. On the last lane it holds.
          if (ob_ready) begin
            if (lane == LAST_LANE) begin
              store_q <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_DONE;
            end else begin
              lane              <= lane + LANE_W'(1);
              op_buffer_address <= op_buffer_address + ADDR_W'(1);
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          accum_q <= 1'b0;
          store_q <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ACC_CTRL_PERF_EN
  logic stall_now;

  assign stall_now = (accum_q & ~psum_valid) | (store_q & ~ob_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (stall_now && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_accumulator_ctrl.sv
// tb/tb_accumulator_ctrl.sv - self-checking bench for accumulator_ctrl

module tb_accumulator_ctrl;

  localparam int ARR = 4;
  localparam int KW  = 8;
  localparam int AW  = 4;
  localparam int L   = 256;

  logic          clk;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic [AW-1:0] base_addr;
  logic          psum_valid;
  logic          ob_ready;
  logic          acc_reset;
  logic          acc_en;
  logic          store_output;
  logic [AW-1:0] op_buffer_address;
  logic          busy;
  logic          done;
  logic          err;
`ifdef ACC_CTRL_PERF_EN
  logic          stall_clr;
  logic [15:0]   stall_cnt;
`endif

  accumulator_ctrl #(.ARR_SIZE(ARR), .K_W(KW), .ADDR_W(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .k_len             (k_len),
    .base_addr         (base_addr),
    .psum_valid        (psum_valid),
    .ob_ready          (ob_ready),
`ifdef ACC_CTRL_PERF_EN
    .stall_clr         (stall_clr),
    .stall_cnt         (stall_cnt),
`endif
    .acc_reset         (acc_reset),
    .acc_en            (acc_en),
    .store_output      (store_output),
    .op_buffer_address (op_buffer_address),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Per-cycle stimulus and expected trace for one tile (index 0 = start cycle).
  bit            pv [L];
  bit            rd [L];
  bit            e_ar [L];
  bit            e_en [L];
  bit            e_so [L];
  bit            e_busy [L];
  bit            e_done [L];
  logic [AW-1:0] e_addr [L];
  int            t_end;
  int            acc_last;
  logic [AW-1:0] prev_addr;
  int            exp_stall;

  task automatic chk(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic fill_random(input int pv_pct, input int rd_pct);
    for (int i = 0; i < L; i++) begin
      pv[i] = (i >= 100) ? 1'b1 : ($urandom_range(99) < pv_pct);
      rd[i] = (i >= 100) ? 1'b1 : ($urandom_range(99) < rd_pct);
    end
  endtask

  // Expected trace from the tile rules: clear one cycle after start, then
  // collect k valid beats, then retire ARR ready lanes, then one done cycle.
  task automatic build_expect(input int k, input int base);
    int c;
    int beats;
    int lanes;
    for (int i = 0; i < L; i++) begin
      e_ar[i] = 0; e_en[i] = 0; e_so[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      e_addr[i] = prev_addr;
    end
    e_ar[1]   = 1;
    e_busy[1] = 1;
    c = 2;
    beats = 0;
    while (beats < k) begin
      e_busy[c] = 1;
      e_en[c]   = pv[c];
      if (pv[c]) beats++;
      else exp_stall++;
      c++;
    end
    acc_last = c - 1;
    lanes = 0;
    while (lanes < ARR) begin
      e_busy[c] = 1;
      e_addr[c] = AW'((base + lanes) % 16);
      e_so[c]   = rd[c];
      if (rd[c]) lanes++;
      else exp_stall++;
      c++;
    end
    e_done[c] = 1;
    for (int j = c; j < L; j++) e_addr[j] = AW'((base + ARR - 1) % 16);
    t_end = c;
    prev_addr = AW'((base + ARR - 1) % 16);
  endtask

  task automatic check_cycle(input int i);
    chk("acc_reset", i, 16'(acc_reset), 16'(e_ar[i]));
    chk("acc_en", i, 16'(acc_en), 16'(e_en[i]));
    chk("store_output", i, 16'(store_output), 16'(e_so[i]));
    chk("op_buffer_address", i, 16'(op_buffer_address), 16'(e_addr[i]));
    chk("busy", i, 16'(busy), 16'(e_busy[i]));
    chk("done", i, 16'(done), 16'(e_done[i]));
    chk("err", i, 16'(err), 16'h0);
  endtask

  task automatic check_idle(input int i, input logic [AW-1:0] a, input bit e_err);
    chk("idle_acc_reset", i, 16'(acc_reset), 16'h0);
    chk("idle_acc_en", i, 16'(acc_en), 16'h0);
    chk("idle_store_output", i, 16'(store_output), 16'h0);
    chk("idle_addr", i, 16'(op_buffer_address), 16'(a));
    chk("idle_busy", i, 16'(busy), 16'h0);
    chk("idle_done", i, 16'(done), 16'h0);
    chk("idle_err", i, 16'(err), 16'(e_err));
  endtask

  // Runs a prepared tile; extra >= 0 injects a second start (with random
  // k_len, possibly 0) during ACCUM; rst_at >= 0 drops reset in that cycle.
  task automatic drive_tile(input int k, input int base, input int extra, input int rst_at);
    for (int i = 0; i <= t_end + 2; i++) begin
      @(posedge clk);
      #1;
      start      = (i == 0) || (i == extra);
      k_len      = (i == 0) ? KW'(k) : KW'($urandom_range(255));
      base_addr  = (i == 0) ? AW'(base) : AW'($urandom_range(15));
      psum_valid = pv[i];
      ob_ready   = rd[i];
      rst        = (i == rst_at) ? 1'b0 : 1'b1;
      @(negedge clk);
      check_cycle(i);
      if (i == rst_at) break;
    end
    if (rst_at >= 0) begin
      exp_stall = 0;
      prev_addr = '0;
      for (int j = 1; j <= 3; j++) begin
        @(posedge clk);
        #1;
        rst        = 1'b1;
        start      = 1'b0;
        psum_valid = 1'($urandom_range(1));
        ob_ready   = 1'($urandom_range(1));
        @(negedge clk);
        check_idle(rst_at + j, '0, 1'b0);
      end
    end
`ifdef ACC_CTRL_PERF_EN
    chk("stall_cnt", t_end, stall_cnt, 16'(exp_stall));
`endif
  endtask

  task automatic drive_err();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start      = (i == 0);
      k_len      = '0;
      base_addr  = AW'($urandom_range(15));
      psum_valid = 1'($urandom_range(1));
      ob_ready   = 1'($urandom_range(1));
      @(negedge clk);
      check_idle(i, prev_addr, (i == 1));
    end
  endtask

  initial begin
    int k;
    int base;
    n_vec      = 0;
    n_err      = 0;
    prev_addr  = '0;
    exp_stall  = 0;
    rst        = 1'b0;
    start      = 1'b0;
    k_len      = '0;
    base_addr  = '0;
    psum_valid = 1'b1;
    ob_ready   = 1'b1;
`ifdef ACC_CTRL_PERF_EN
    stall_clr  = 1'b0;
`endif

    // Reset state, with inputs deliberately active.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle(i, '0, 1'b0);
`ifdef ACC_CTRL_PERF_EN
      chk("reset_stall_cnt", i, stall_cnt, 16'h0);
`endif
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic tile: k=3, base 2, no stalls.
    fill_random(100, 100);
    build_expect(3, 2);
    drive_tile(3, 2, -1, -1);

    // Accumulation stalls: beats at pattern 1,0,0,1.
    fill_random(100, 100);
    pv[2] = 1; pv[3] = 0; pv[4] = 0; pv[5] = 1;
    build_expect(2, 7);
    drive_tile(2, 7, -1, -1);

    // Output backpressure: ready pattern 0,1,0,1,1,1 from the first STORE cycle.
    fill_random(100, 100);
    rd[3] = 0; rd[4] = 1; rd[5] = 0; rd[6] = 1; rd[7] = 1; rd[8] = 1;
    build_expect(1, 0);
    drive_tile(1, 0, -1, -1);

    // Address wrap past 15.
    fill_random(100, 100);
    build_expect(3, 14);
    drive_tile(3, 14, -1, -1);

    // k_len == 0 start is rejected.
    drive_err();

    // Second start during ACCUM is ignored.
    fill_random(100, 100);
    build_expect(5, 3);
    drive_tile(5, 3, 3, -1);

    // Reset during STORE after two lanes, then a fresh tile.
    fill_random(100, 100);
    build_expect(2, 5);
    drive_tile(2, 5, -1, 6);
    fill_random(100, 100);
    build_expect(4, 9);
    drive_tile(4, 9, -1, -1);

    // Randomised tiles.
    for (int t = 0; t < 25; t++) begin
      k    = $urandom_range(10, 1);
      base = $urandom_range(15);
      fill_random($urandom_range(100, 30), $urandom_range(100, 30));
      build_expect(k, base);
      drive_tile(k, base, (t % 2 == 0) ? int'($urandom_range(acc_last, 2)) : -1, -1);
      if (t % 5 == 4) drive_err();
    end

`ifdef ACC_CTRL_PERF_EN
    @(posedge clk);
    #1;
    stall_clr = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    stall_clr = 1'b0;
    @(negedge clk);
    chk("stall_clr", 0, stall_cnt, 16'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
